fir_shift_pipe: RTL
===================

FIR_SHIFT_PIPE -- requirements
Module: fir_shift_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, input sample width (unsigned).
REQ-002 SHALL have parameter TAPS, default 8, delay-line depth (2..32).
REQ-003 SHALL have parameter OUT_W, default 16, result width; OUT_W >= DATA_W.
REQ-004 SHALL have parameter SHIFT_W, default 4, per-tap shift-amount width.
REQ-005 SHALL have port clock  in  1  single rising-edge clock.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 SHALL have port in_valid  in  1  input sample present.
REQ-008 SHALL have port in_data  in  DATA_W  input sample.
REQ-009 SHALL have port in_ready  out  1  block accepts sample this cycle.
REQ-010 SHALL have port out_valid  out  1  out_data holds a result.
REQ-011 SHALL have port out_data  out  OUT_W  filter result.
REQ-012 SHALL have port out_ready  in  1  downstream accepts result.
REQ-013 SHALL have port cfg_we  in  1  shift-table write strobe.
REQ-014 SHALL have port cfg_tap  in  5  tap index to write (0 = newest).
REQ-015 SHALL have port cfg_shift  in  SHIFT_W  shift amount to write.
REQ-016 SHALL have port flush  in  1  synchronous clear of delay line and pipeline.
REQ-017 SHALL have port ovf  out  1  sticky overflow flag.

Function
REQ-018 SHALL define advance = !out_valid | out_ready, and drive in_ready = advance.
REQ-019 SHALL define accept = in_valid & in_ready & !flush.
REQ-020 SHALL, on accept, shift the TAPS-deep delay line one place: tap0 <- in_data, tap k <- tap k-1, and discard the oldest sample.
REQ-021 SHALL leave the delay line unchanged on any cycle without accept.
REQ-022 SHALL compute the result as the sum over k of (tapk >> shift[k]), using in_data as tap0 and the pre-shift tap k-1 contents as tap k, zero-extended to OUT_W+1 bits.
REQ-023 SHALL contribute 0 for any tap whose shift[k] >= DATA_W.
REQ-024 SHALL use a 2-stage pipeline:
- stage A (sum, valid) loads on each advance edge with valid = accept;
- stage B (out_data, out_valid) loads from stage A on each advance edge;
- a sample accepted at edge N gives a result visible after edge N+1, with no stall.
REQ-025 SHALL hold stage A, stage B, out_data and out_valid stable while advance = 0.
REQ-026 SHALL deliver results in acceptance order, with no duplication or loss under any out_ready pattern.
REQ-027 SHALL saturate out_data to 2^OUT_W-1 when the sum exceeds it, and set ovf on the stage-B load of that result.
REQ-028 SHALL keep ovf set until flush or reset.
REQ-029 SHALL, on cfg_we, write shift[cfg_tap] <- cfg_shift at the clock edge, and ignore the write if cfg_tap >= TAPS.
REQ-030 SHALL apply a config write on the same edge as an accept to samples accepted after that edge only.
REQ-031 SHALL, on flush, synchronously clear every delay-line tap, stage A, stage B, out_valid and ovf to 0 without altering the shift table.
REQ-032 SHALL give flush priority over accept and advance.
REQ-033 SHALL drop the in_data presented in a flush cycle.

Reset
REQ-034 SHALL, while reset = 0, asynchronously force to 0: delay line, stage A, out_data, out_valid and ovf.
REQ-035 SHALL, while reset = 0, hold shift[k] = k+1 (tap0 = 1 ... tap7 = 8 for defaults), truncated to SHIFT_W.
REQ-036 SHALL drive in_ready = 1 in the first cycle after reset deasserts.
REQ-037 SHALL return to the REQ-034/REQ-035 state on reset mid-stream and discard in-flight results.

Verification
REQ-038 SHALL cover default config, out_ready = 1, stream 4, 2, 6, 10 -> out_data 2, 2, 3, 6, each valid one cycle after its accept cycle.
REQ-039 SHALL cover all shifts written 0, eight samples of 255 -> eighth result 2040, ovf = 0; repeat with OUT_W = 10 -> out_data 1023, ovf = 1.
REQ-040 SHALL cover out_ready = 0 for 5 cycles after the first result -> in_ready = 0, out_data and out_valid held, no sample lost when released.
REQ-041 SHALL cover cfg_we tap0 shift = 8, input 200 -> result 0 for that tap.
REQ-042 SHALL cover reset pulse mid-stream -> all outputs 0 immediately; after release, input 4 -> out_data 2.
REQ-043 SHALL cover flush with in_valid = 1 and stage B full -> next cycle out_valid = 0; next input 4 -> out_data 2.

Source files
------------

// File: rtl/fir_shift_pipe.sv
// fir_shift_pipe: shift-and-add FIR over a TAPS-deep delay line, 2-stage pipe.
// Ports: clock/reset, in valid/ready/data, out valid/ready/data, cfg write, flush, ovf.
module fir_shift_pipe #(
    parameter int DATA_W  = 8,
    parameter int TAPS    = 8,
    parameter int OUT_W   = 16,
    parameter int SHIFT_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [OUT_W-1:0]   out_data,
    input  logic               out_ready,
    input  logic               cfg_we,
    input  logic [4:0]         cfg_tap,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               flush,
    output logic               ovf
);

    localparam int SW = OUT_W + 1;

    logic [DATA_W-1:0]  line  [TAPS];
    logic [SHIFT_W-1:0] shamt [TAPS];
    logic [DATA_W-1:0]  tv    [TAPS];
    logic [SW-1:0]      sum;
    logic [SW-1:0]      a_sum;
    logic               a_valid;
    logic               advance;
    logic               accept;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance && !flush;

    // The incoming sample acts as tap0, so the result reflects the
    // delay line as it will look right after this accept.
    always_comb begin
        tv[0] = in_data;
        for (int k = 1; k < TAPS; k++) begin
            tv[k] = line[k-1];
        end
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            if (32'(shamt[k]) < DATA_W) begin
                sum = sum + {{(SW-DATA_W){1'b0}}, tv[k] >> shamt[k]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                line[k] <= '0;
            end
            a_sum     <= '0;
            a_valid   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else if (flush) begin
            for (int k = 0; k < TAPS; k++) begin
                line[k] <= '0;
            end
            a_sum     <= '0;
            a_valid   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (accept) begin
                line[0] <= in_data;
                for (int k = 1; k < TAPS; k++) begin
                    line[k] <= line[k-1];
                end
            end
            if (advance) begin
                a_sum     <= sum;
                a_valid   <= accept;
                out_valid <= a_valid;
                out_data  <= a_sum[OUT_W] ? '1 : a_sum[OUT_W-1:0];
                if (a_valid && a_sum[OUT_W]) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    // Indices >= TAPS match no entry, so such writes fall away.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                shamt[k] <= SHIFT_W'(k + 1);
            end
        end else if (cfg_we) begin
            for (int k = 0; k < TAPS; k++) begin
                if (cfg_tap == 5'(k)) begin
                    shamt[k] <= cfg_shift;
                end
            end
        end
    end

endmodule
